// File: rtl/alu_operand_loader.sv
// Nibble-serial operand entry for the ALU: a debounced step button loads A, B,
// Opcode and Cin from the slide switches and then holds them for the ALU.
module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn,
  input  logic        clear,
  input  logic [3:0]  sw,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [3:0]  Opcode,
  output logic        Cin,
  output logic [2:0]  stage,
  output logic [1:0]  nibble_idx,
  output logic        valid,
  output logic        go
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    LOAD_A   = 3'd0,
    LOAD_B   = 3'd1,
    LOAD_OP  = 3'd2,
    LOAD_CIN = 3'd3,
    READY    = 3'd4
  } state_t;

  logic          sync1_r;
  logic          btn_sync_r;
  logic          btn_db_r;
  logic          btn_db_d_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    sw_q_r;
  logic          step_s;

  state_t        state_r;
  state_t        state_next_s;
  logic [15:0]   a_next_s;
  logic [15:0]   b_next_s;
  logic [3:0]    op_next_s;
  logic          cin_next_s;
  logic [1:0]    idx_next_s;

  // Button synchronizer, debounce counter, edge-detect delay and switch sampling
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r    <= 1'b0;
      btn_sync_r <= 1'b0;
      btn_db_r   <= 1'b0;
      btn_db_d_r <= 1'b0;
      cnt_r      <= '0;
      sw_q_r     <= 4'd0;
    end else begin
      sync1_r    <= btn;
      btn_sync_r <= sync1_r;
      btn_db_d_r <= btn_db_r;
      sw_q_r     <= sw;
      if (btn_sync_r != btn_db_r) begin
        if (cnt_r == CNT_MAX) begin
          btn_db_r <= btn_sync_r;
          cnt_r    <= '0;
        end else begin
          cnt_r    <= cnt_r + CW'(1'b1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  // Only the debounced rising edge advances entry; release is ignored
  assign step_s = btn_db_r & ~btn_db_d_r;

  // Next-state and next-value logic for the entry sequencer
  always_comb begin
    state_next_s = state_r;
    a_next_s     = A;
    b_next_s     = B;
    op_next_s    = Opcode;
    cin_next_s   = Cin;
    idx_next_s   = nibble_idx;
    case (state_r)
      LOAD_A: begin
        if (step_s) begin
          a_next_s   = {A[11:0], sw_q_r};
          idx_next_s = nibble_idx + 2'd1;
          if (nibble_idx == 2'd3) begin
            state_next_s = LOAD_B;
          end else begin
            state_next_s = LOAD_A;
          end
        end else begin
          state_next_s = LOAD_A;
        end
      end
      LOAD_B: begin
        if (step_s) begin
          b_next_s   = {B[11:0], sw_q_r};
          idx_next_s = nibble_idx + 2'd1;
          if (nibble_idx == 2'd3) begin
            state_next_s = LOAD_OP;
          end else begin
            state_next_s = LOAD_B;
          end
        end else begin
          state_next_s = LOAD_B;
        end
      end
      LOAD_OP: begin
        if (step_s) begin
          op_next_s    = sw_q_r;
          state_next_s = LOAD_CIN;
        end else begin
          state_next_s = LOAD_OP;
        end
      end
      LOAD_CIN: begin
        if (step_s) begin
          cin_next_s   = sw_q_r[0];
          state_next_s = READY;
        end else begin
          state_next_s = LOAD_CIN;
        end
      end
      READY: begin
        // A step here restarts entry; the switches are deliberately not captured
        if (step_s) begin
          a_next_s     = 16'd0;
          b_next_s     = 16'd0;
          op_next_s    = 4'd0;
          cin_next_s   = 1'b0;
          idx_next_s   = 2'd0;
          state_next_s = LOAD_A;
        end else begin
          state_next_s = READY;
        end
      end
      default: begin
        state_next_s = LOAD_A;
      end
    endcase
  end

  // Sequencer registers; clear behaves like reset but leaves the debouncer alone
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_r    <= LOAD_A;
      A          <= 16'd0;
      B          <= 16'd0;
      Opcode     <= 4'd0;
      Cin        <= 1'b0;
      nibble_idx <= 2'd0;
      valid      <= 1'b0;
      go         <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      A          <= a_next_s;
      B          <= b_next_s;
      Opcode     <= op_next_s;
      Cin        <= cin_next_s;
      nibble_idx <= idx_next_s;
      valid      <= (state_next_s == READY);
      go         <= (state_next_s == READY) && (state_r != READY);
    end
  end

  assign stage = state_r;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Randomized self-checking bench for alu_operand_loader; expected outputs come
// from a queue of entered nibbles rather than a copy of the sequencer.
module tb_alu_operand_loader;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn;
  logic        clear;
  logic [3:0]  sw;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  Opcode;
  logic        Cin;
  logic [2:0]  stage;
  logic [1:0]  nibble_idx;
  logic        valid;
  logic        go;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: nibbles accepted since the last restart (10 = complete op)
  logic [3:0] q[$];

  alu_operand_loader #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .btn(btn), .clear(clear), .sw(sw),
    .A(A), .B(B), .Opcode(Opcode), .Cin(Cin), .stage(stage),
    .nibble_idx(nibble_idx), .valid(valid), .go(go)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] m_operand(input int base);
    logic [15:0] v = 16'd0;
    for (int i = base; i < base + 4 && i < q.size(); i++) v = {v[11:0], q[i]};
    return v;
  endfunction

  function automatic logic [2:0] m_stage();
    int n = q.size();
    if (n < 4) return 3'd0;
    if (n < 8) return 3'd1;
    if (n == 8) return 3'd2;
    if (n == 9) return 3'd3;
    return 3'd4;
  endfunction

  task automatic check_state(input string tag);
    int n = q.size();
    logic [3:0] op_e  = (n >= 9) ? q[8] : 4'd0;
    logic [3:0] cin_n = (n >= 10) ? q[9] : 4'd0;
    chk({tag, "_A"}, A, m_operand(0));
    chk({tag, "_B"}, B, m_operand(4));
    chk({tag, "_Opcode"}, Opcode, op_e);
    chk({tag, "_Cin"}, Cin, cin_n[0]);
    chk({tag, "_stage"}, stage, m_stage());
    chk({tag, "_nibble_idx"}, nibble_idx, (n < 8) ? (n % 4) : 0);
    chk({tag, "_valid"}, valid, (n == 10) ? 1 : 0);
  endtask

  // One full press/release; collide asserts clear during the step cycle
  task automatic press(input logic [3:0] v, input bit collide);
    sw  = v;
    btn = 1'b1;
    tick(DB + 2);
    check_state("pre");
    chk("pre_go", go, 0);
    if (collide) begin
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      q.delete();
    end else begin
      tick(1);
      if (q.size() == 10) q.delete();
      else q.push_back(v);
    end
    check_state("post");
    chk("post_go", go, (q.size() == 10) ? 1 : 0);
    btn = 1'b0;
    sw  = 4'($urandom);
    tick(1);
    chk("go_fall", go, 0);
    check_state("hold");
    tick(DB + 3);
    check_state("released");
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    q.delete();
    check_state("clear");
    chk("clear_go", go, 0);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    q.delete();
    check_state("reset");
    chk("reset_go", go, 0);
  endtask

  initial begin
    logic [3:0] seq [10] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD, 4'h6, 4'h1};
    btn   = 1'b0;
    clear = 1'b0;
    sw    = 4'd0;
    #1;
    reset_pulse();

    // Bounce shorter than the debounce window never steps
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0);
      tick(2);
      check_state("bounce");
    end
    btn = 1'b0;
    tick(DB + 4);
    check_state("bounce_end");

    // Directed full entry, then restart from READY
    foreach (seq[i]) press(seq[i], 1'b0);
    chk("full_A", A, 16'h1234);
    chk("full_B", B, 16'hABCD);
    chk("full_Opcode", Opcode, 4'h6);
    chk("full_Cin", Cin, 1'b1);
    chk("full_valid", valid, 1'b1);
    press(4'hF, 1'b0);
    chk("restart_A", A, 16'h0000);
    chk("restart_stage", stage, 3'd0);

    // Mid-entry clear discards partial nibbles
    press(4'h1, 1'b0);
    press(4'h2, 1'b0);
    chk("partial_A", A, 16'h0012);
    clear_pulse();
    press(4'h7, 1'b0);
    chk("after_clear_A", A, 16'h0007);

    // Clear wins over a coincident step
    press(4'h9, 1'b1);
    chk("collide_A", A, 16'h0000);

    // Randomized mix of presses, clears, collisions and resets
    for (int i = 0; i < 70; i++) begin
      int r = $urandom_range(0, 19);
      if (r == 0) clear_pulse();
      else if (r == 1) press(4'($urandom), 1'b1);
      else if (r == 2) reset_pulse();
      else press(4'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Operand-entry sequencer that sits directly upstream of the ALU display stage on the board. It turns one raw step push-button and four slide switches into full 16-bit A/B operands, a 4-bit opcode and a carry-in, loaded one nibble per press. It holds those values stable for the ALU, and signals when a complete operation has been entered. It includes its own button synchronizer and debouncer.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive cycles the synchronized button must disagree with the debounced level before the level flips. Minimum 2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high. Returns all state to reset values.
- btn  in  1  raw, bouncy, asynchronous step button (high = pressed).
- clear  in  1  synchronous clean level. Restarts entry; no debounce applied.
- sw  in  4  slide switches. Sampled through one register stage (sw_q).
- A  out  16  operand A.
- B  out  16  operand B.
- Opcode  out  4  ALU opcode.
- Cin  out  1  carry-in.
- stage  out  3  current FSM state encoding.
- nibble_idx  out  2  nibble position within the current operand.
- valid  out  1  high while a complete operation is held.
- go  out  1  one-cycle pulse on entry to READY.

## Operation
- Button path:
  - btn passes through a 2-flop synchronizer, giving btn_s.
  - A counter increments each cycle that btn_s != btn_db. It is forced to 0 whenever they are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and btn_s still differs, btn_db <= btn_s and the counter resets to 0.
  - step = btn_db & ~btn_db_d, where btn_db_d is btn_db delayed one cycle. It is high for exactly one cycle per debounced press. Release produces no step.
- FSM states and stage encoding: LOAD_A=0, LOAD_B=1, LOAD_OP=2, LOAD_CIN=3, READY=4. The remaining encodings are unreachable; if entered, the FSM goes to LOAD_A next cycle.
- LOAD_A, on step:
  - A <= {A[11:0], sw_q}. Entry is MSB nibble first.
  - nibble_idx increments.
  - The step with nibble_idx==3 moves to LOAD_B and wraps nibble_idx to 0.
- LOAD_B: same as LOAD_A, but applied to B. The 4th step moves to LOAD_OP.
- LOAD_OP, on step: Opcode <= sw_q, then move to LOAD_CIN.
- LOAD_CIN, on step: Cin <= sw_q[0], then move to READY. go is high during the first cycle in READY.
- READY:
  - valid=1. A, B, Opcode and Cin are held.
  - On step: A, B, Opcode and Cin are cleared to 0, nibble_idx=0, and the FSM moves to LOAD_A. The switches are not captured on this step.
- Without a step, all registers hold.
- clear=1 has the same effect as reset on A, B, Opcode, Cin, stage, nibble_idx, valid and go. The debouncer state is not affected by clear.
- Priority, highest first: reset, clear, step.
- valid is a registered output equal to (stage==READY).

## Timing
- Reset values: A=0, B=0, Opcode=0, Cin=0, stage=0 (LOAD_A), nibble_idx=0, valid=0, go=0. Internally btn_db=0, btn_db_d=0, counter=0, synchronizer flops=0, sw_q=0.
- Press latency:
  - btn goes high before edge 1 and stays stable.
  - btn_s is high after edge 2.
  - btn_db is high after edge 2+DEBOUNCE_CYCLES.
  - step is high during the following cycle.
  - Register and output updates become visible after edge 3+DEBOUNCE_CYCLES.
- Switch capture: the value captured is sw_q during the step cycle, which is sw as sampled one edge earlier.
- A bounce shorter than DEBOUNCE_CYCLES cycles produces no step and restarts the count.
- go and valid rise on the same edge. go falls one cycle later; valid stays high until leaving READY.
- Reset or clear asserted mid-entry: outputs take their reset values on that edge. Partially entered nibbles are discarded.
- A step that coincides with clear=1 is lost. A held button yields no further step until it has been released and debounced.

## Test plan
Run with DEBOUNCE_CYCLES=4.
- Reset check: assert reset for 2 cycles. Then all outputs are 0 and stage=0.
- Bounce rejection:
  - btn toggles every 2 cycles for 20 cycles, then stays 0: step is never high and A stays 0.
  - btn stable high: the first update appears exactly 7 edges after btn first rises.
- Full entry:
  - Press sequence with sw = 1,2,3,4 | A,B,C,D | 6 | 1 gives A=16'h1234, B=16'hABCD, Opcode=6, Cin=1.
  - go pulses high for exactly 1 cycle and valid=1 afterwards.
  - stage/nibble_idx step through 0/0..0/3, 1/0..1/3, 2, 3, 4.
- READY restart: one more press returns to stage=0 with A=B=0, Opcode=0, Cin=0 and valid=0. sw is ignored on that press.
- Mid-entry clear: after 2 nibbles of A (A=16'h0012), assert clear for 1 cycle. A=0, nibble_idx=0 and stage=0. The next nibble loads as A=16'h0007 when sw=7.
- Clear/step collision: assert clear during the step cycle. Clear wins: the outputs reset and the nibble is not captured.
